// File: rtl/multicycle_control_unit.sv
// Main controller for the multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback, inserts synchronous-read
// memory wait states and halts on ECALL, EBREAK or an unknown opcode.
// Controls are a function of the current state and the instruction-register
// fields. Zero is only consulted for the branch PC enable.
module multicycle_control_unit #(
  parameter int MEM_WAIT = 1  // extra cycles in FETCH / MEMREAD (0..7)
) (
  input  logic       clk,
  input  logic       reset,        // asynchronous, active low
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       halted,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR,
    S_JALR_JMP, S_LUI, S_AUIPC, S_HALT
  } state_t;

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic       illegal_q;
  logic       wait_done;
  logic       br_taken;
  logic [3:0] br_alu;
  logic       unused_f7;

  // only funct7[5] distinguishes SUB/SRA; the other bits are don't-care here
  assign unused_f7 = ^{funct7[6], funct7[4:0]};
  assign wait_done = (cnt == 3'(MEM_WAIT));

  // funct3 -> ALU op; SUB only exists for register-register ops
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5,
                                        input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // branch compare op and taken decision from the ALU Zero flag
  always_comb begin
    br_alu   = ALU_SUB;
    br_taken = 1'b0;
    case (funct3)
      3'b000: begin br_alu = ALU_SUB;  br_taken = Zero;  end
      3'b001: begin br_alu = ALU_SUB;  br_taken = !Zero; end
      3'b100: begin br_alu = ALU_SLT;  br_taken = !Zero; end
      3'b101: begin br_alu = ALU_SLT;  br_taken = Zero;  end
      3'b110: begin br_alu = ALU_SLTU; br_taken = !Zero; end
      3'b111: begin br_alu = ALU_SLTU; br_taken = Zero;  end
      default: ;
    endcase
  end

  // next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:    if (wait_done) state_nx = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R:              state_nx = S_EXEC_R;
          OP_I:              state_nx = S_EXEC_I;
          OP_BRANCH:         state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          OP_JALR:           state_nx = S_JALR_ADR;
          OP_LUI:            state_nx = S_LUI;
          OP_AUIPC:          state_nx = S_AUIPC;
          OP_FENCE:          state_nx = S_FETCH;
          default:           state_nx = S_HALT;  // SYSTEM or unknown
        endcase
      end
      S_MEMADR:   state_nx = (op_code == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (wait_done) state_nx = S_MEMWB;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: state_nx = S_FETCH;
      S_EXEC_R:   state_nx = S_ALUWB;
      S_EXEC_I:   state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_JAL:      state_nx = S_ALUWB;
      S_JALR_ADR: state_nx = S_JALR_JMP;
      S_JALR_JMP: state_nx = S_ALUWB;
      S_LUI:      state_nx = S_FETCH;
      S_AUIPC:    state_nx = S_ALUWB;
      S_HALT:     state_nx = S_HALT;
      default:    state_nx = S_FETCH;
    endcase
  end

  // state, wait counter (cleared on every state change) and halt cause
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        cnt <= '0;
      else if (state == S_FETCH || state == S_MEMREAD)
        cnt <= cnt + 3'd1;
      if (state == S_DECODE && state_nx == S_HALT && op_code != OP_SYSTEM)
        illegal_q <= 1'b1;
    end
  end

  // per-state datapath controls; everything held at 0 while in reset
  always_comb begin
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    IR_write    = 1'b0;
    reg_write   = 1'b0;
    PC_write    = 1'b0;
    result_src  = 2'd0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    halted      = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          alu_src_b  = 2'd2;
          result_src = 2'd2;
          if (wait_done) begin
            IR_write = 1'b1;
            PC_write = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          imm_src   = (op_code == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          imm_src   = (op_code == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD:  adr_src = 1'b1;
        S_MEMWB: begin
          result_src = 2'd1;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a   = 2'd2;
          alu_control = alu_op(funct3, funct7[5], 1'b1);
        end
        S_EXEC_I: begin
          alu_src_a   = 2'd2;
          alu_src_b   = 2'd1;
          alu_control = alu_op(funct3, funct7[5], 1'b0);
        end
        S_ALUWB:    reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = 2'd2;
          alu_control = br_alu;
          PC_write    = br_taken;
        end
        S_JAL, S_JALR_JMP: begin
          PC_write  = 1'b1;
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
        end
        S_JALR_ADR: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
        end
        S_LUI: begin
          imm_src    = IMM_U;
          result_src = 2'd3;
          reg_write  = 1'b1;
        end
        S_AUIPC: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          imm_src   = IMM_U;
        end
        S_HALT:     halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: each instruction is expanded by a
// per-opcode schedule into the list of control words it must produce, one
// per cycle, and the DUT is compared against that list every cycle.
module tb_multicycle_control_unit;
  localparam int MEM_WAIT = 1;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       IR_write;
    logic       reg_write;
    logic       PC_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       halted;
    logic       illegal_instr;
  } cw_t;

  typedef struct packed {
    logic [31:0] ir;
    logic        z;
    cw_t         cw;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op_code = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       Zero = 1'b0;
  logic       adr_src, mem_write, IR_write, reg_write, PC_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       halted, illegal_instr;

  ent_t        q[$];
  cw_t         exp_cw = '0;
  logic [31:0] cur_ir = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          halt_cycles = 20;
  int          f3alu[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
  int          bralu[8] = '{1, 1, 1, 1, 5, 5, 6, 6};

  multicycle_control_unit #(.MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3),
    .funct7(funct7), .Zero(Zero), .adr_src(adr_src), .mem_write(mem_write),
    .IR_write(IR_write), .reg_write(reg_write), .PC_write(PC_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .halted(halted),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  function automatic cw_t cw(int adr, int mw, int irw, int rw, int pcw,
                             int rs, int a, int b, int imm, int alu);
    cw_t c;
    c = '0;
    c.adr_src     = 1'(adr);
    c.mem_write   = 1'(mw);
    c.IR_write    = 1'(irw);
    c.reg_write   = 1'(rw);
    c.PC_write    = 1'(pcw);
    c.result_src  = 2'(rs);
    c.alu_src_a   = 2'(a);
    c.alu_src_b   = 2'(b);
    c.imm_src     = 3'(imm);
    c.alu_control = 4'(alu);
    return c;
  endfunction

  function automatic logic rz();
    return $urandom_range(0, 1) == 1;
  endfunction

  task automatic push(input logic [31:0] ins, input logic z, input cw_t c);
    ent_t e;
    e.ir = ins;
    e.z  = z;
    e.cw = c;
    q.push_back(e);
  endtask

  // expected control words, cycle by cycle, for one instruction
  task automatic build(input logic [31:0] ins, input logic zb);
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b;
    int         alu;
    int         taken;
    cw_t        aluwb;
    cw_t        h;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7b = ins[30];
    aluwb = cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MEM_WAIT; i++) push(ins, rz(), cw(0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    push(ins, rz(), cw(0, 0, 1, 0, 1, 2, 0, 2, 0, 0));
    push(ins, rz(), cw(0, 0, 0, 0, 0, 0, 1, 1, (op == 7'h6F) ? 3 : 2, 0));
    case (op)
      7'h03: begin
        push(ins, rz(), cw(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        for (int i = 0; i <= MEM_WAIT; i++) push(ins, rz(), cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(ins, rz(), cw(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      end
      7'h23: begin
        push(ins, rz(), cw(0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
        push(ins, rz(), cw(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      7'h33: begin
        alu = f3alu[f3] + (((f3 == 0 || f3 == 5) && f7b) ? 1 : 0);
        push(ins, rz(), cw(0, 0, 0, 0, 0, 0, 2, 0, 0, alu));
        push(ins, rz(), aluwb);
      end
      7'h13: begin
        alu = f3alu[f3] + ((f3 == 5 && f7b) ? 1 : 0);
        push(ins, rz(), cw(0, 0, 0, 0, 0, 0, 2, 1, 0, alu));
        push(ins, rz(), aluwb);
      end
      7'h63: begin
        if (f3 == 0 || f3 == 5 || f3 == 7) taken = zb ? 1 : 0;
        else if (f3 == 1 || f3 == 4 || f3 == 6) taken = zb ? 0 : 1;
        else taken = 0;
        push(ins, zb, cw(0, 0, 0, 0, taken, 0, 2, 0, 0, bralu[f3]));
      end
      7'h6F: begin
        push(ins, rz(), cw(0, 0, 0, 0, 1, 0, 1, 2, 0, 0));
        push(ins, rz(), aluwb);
      end
      7'h67: begin
        push(ins, rz(), cw(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        push(ins, rz(), cw(0, 0, 0, 0, 1, 0, 1, 2, 0, 0));
        push(ins, rz(), aluwb);
      end
      7'h37: push(ins, rz(), cw(0, 0, 0, 1, 0, 3, 0, 0, 4, 0));
      7'h17: begin
        push(ins, rz(), cw(0, 0, 0, 0, 0, 0, 1, 1, 4, 0));
        push(ins, rz(), aluwb);
      end
      7'h0F: ;
      default: begin
        h = '0;
        h.halted = 1'b1;
        h.illegal_instr = (op != 7'h73);
        for (int i = 0; i < halt_cycles; i++) push(ins, rz(), h);
      end
    endcase
  endtask

  // one cycle: compare at the falling edge, then step past the next rising edge
  task automatic tick();
    cw_t act;
    @(negedge clk);
    act = {adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, halted, illegal_instr};
    n_chk++;
    if (act !== exp_cw) begin
      n_fail++;
      $display("FAIL ctrl ir=%h t=%0t: got %h want %h", cur_ir, $time, act, exp_cw);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic play(input int n);
    ent_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      cur_ir  = e.ir;
      op_code = e.ir[6:0];
      funct3  = e.ir[14:12];
      funct7  = e.ir[31:25];
      Zero    = e.z;
      exp_cw  = e.cw;
      tick();
    end
  endtask

  task automatic hold_reset(input int n);
    reset  = 1'b0;
    exp_cw = '0;
    for (int i = 0; i < n; i++) begin
      Zero    = rz();
      op_code = 7'($urandom);
      funct3  = 3'($urandom);
      funct7  = 7'($urandom);
      tick();
    end
    reset = 1'b1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic run(input string name, input logic [31:0] ins, input logic z,
                     input int len);
    build(ins, z);
    if (len > 0) chk({name, "_len"}, q.size(), len);
    play(1000);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [6:0]  ops[10];
    logic [2:0]  bf3[6];
    int          k;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    r = $urandom;
    k = $urandom_range(0, 9);
    r[6:0] = ops[k];
    if (k == 4) r[14:12] = bf3[$urandom_range(0, 5)];
    return r;
  endfunction

  initial begin
    hold_reset(3);
    // directed instructions; lengths assume MEM_WAIT=1
    run("add",   32'h002081B3, 1'b0, 5);
    run("sub",   32'h402081B3, 1'b0, 5);
    run("lw",    32'h0000A183, 1'b0, 7);
    run("sw",    32'h0030A023, 1'b0, 5);
    run("beq_t", 32'h00208463, 1'b1, 4);
    run("beq_n", 32'h00208463, 1'b0, 4);
    build(32'h0020D463, 1'b0);
    chk("bge_len", q.size(), 4);
    chk("bge_alu", int'(q[MEM_WAIT + 2].cw.alu_control), 5);
    chk("bge_pcw", int'(q[MEM_WAIT + 2].cw.PC_write), 0);
    play(1000);
    run("jal",   32'h008000EF, 1'b0, 5);
    run("jalr",  32'h000080E7, 1'b0, 6);
    run("lui",   32'h123451B7, 1'b0, 4);
    run("auipc", 32'h00001197, 1'b0, 5);
    run("fence", 32'h0000000F, 1'b0, 3);
    run("srai",  32'h4030D193, 1'b0, 5);
    run("addi7", 32'h40308193, 1'b0, 5);
    // randomized instruction stream
    for (int i = 0; i < 150; i++) run("rand", rand_ins(), rz(), 0);
    // reset in the first MEMREAD cycle of a load aborts it
    build(32'h0000A183, 1'b0);
    play(MEM_WAIT + 4);
    q.delete();
    hold_reset(2);
    run("add2", 32'h002081B3, 1'b0, 5);
    // illegal opcode halts and flags; reset clears it
    run("illegal", 32'h0000007F, 1'b0, 0);
    hold_reset(2);
    halt_cycles = 5;
    run("ecall", 32'h00000073, 1'b0, 0);
    hold_reset(2);
    run("add3", 32'h402081B3, 1'b0, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style main controller that sequences the multicycle RV32I datapath: fetch, decode, execute, memory access and writeback.
- Decodes op_code, funct3 and funct7 from the instruction register, plus Zero from the ALU.
- Drives every datapath select and enable each cycle. Instantiated beside the datapath at the core top level.
- Handles synchronous-read memory wait states, and halts on ECALL, EBREAK or an illegal opcode.

Parameters:
MEM_WAIT, 1, extra cycles held in the fetch and load-read states before data is consumed (0..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
op_code  input  7  instruction[6:0]
funct3  input  3  instruction[14:12]
funct7  input  7  instruction[31:25]
Zero  input  1  ALU result == 0
adr_src  output  1  0=PC, 1=result
mem_write  output  1  data memory write enable
IR_write  output  1  instruction/old_PC register enable
reg_write  output  1  register file write enable
PC_write  output  1  PC enable
result_src  output  2  0=ALU_out, 1=dmem_data, 2=ALU_result, 3=immed_extend
alu_src_a  output  2  0=PC, 1=old_PC, 2=rs1 flop
alu_src_b  output  2  0=rs2 flop, 1=immed_extend, 2=constant 4
imm_src  output  3  0=I, 1=S, 2=B, 3=J, 4=U
alu_control  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
halted  output  1  core stopped
illegal_instr  output  1  halt cause was an unknown opcode

Behaviour:
Reset:
- While reset=0: state=FETCH, wait counter=0, halted=0, illegal_instr=0.
- All enables (mem_write, IR_write, reg_write, PC_write) are forced 0.
- Select outputs are 0.

Outputs:
- All outputs are a function of state plus the registered instruction fields only.
- Zero is used only for PC_write in BRANCH.
- Unlisted controls are 0.

States and transitions:
- FETCH: adr_src=0, a=0, b=2, ADD, result_src=2. Counter counts MEM_WAIT cycles with no enables. On the final cycle, IR_write=1 and PC_write=1; next state is DECODE.
- DECODE: a=1, b=1, ADD, imm_src=J if op_code=1101111, else B. ALU_out becomes the jump/branch target.
  - Next state by op_code: 0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR_ADR; 0110111 -> LUI; 0010111 -> AUIPC; 1110011 -> HALT; 0001111 (fence) -> FETCH.
  - Any other op_code -> HALT with illegal_instr=1.
- MEMADR: a=2, b=1, ADD, imm_src=S for stores, I for loads. Next: MEMREAD (load) or MEMWRITE (store).
- MEMREAD: adr_src=1, result_src=0. Held 1+MEM_WAIT cycles, then MEMWB.
- MEMWB: result_src=1, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=0, mem_write=1 for exactly one cycle, then FETCH.
- EXEC_R: a=2, b=0, alu_control from funct3/funct7, then ALUWB.
  - funct3 000: ADD, or SUB if funct7[5]=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRL, or SRA if funct7[5]=1.
  - 110 OR, 111 AND.
- EXEC_I: a=2, b=1, imm_src=I, same funct3 mapping, then ALUWB.
  - funct7[5] selects SRA only for funct3=101; ADDI never becomes SUB.
- ALUWB: result_src=0, reg_write=1, then FETCH.
- BRANCH: a=2, b=0, result_src=0, then FETCH.
  - beq/bne: SUB. blt/bge: SLT. bltu/bgeu: SLTU.
  - PC_write=1 when taken: beq Zero; bne !Zero; blt/bltu !Zero; bge/bgeu Zero.
- JAL: result_src=0, PC_write=1, a=1, b=2, ADD, then ALUWB.
- JALR_ADR: a=2, b=1, imm_src=I, ADD, then JALR_JMP.
- JALR_JMP: result_src=0, PC_write=1, a=1, b=2, ADD, then ALUWB. Target bit 0 is not cleared.
- LUI: imm_src=U, result_src=3, reg_write=1, then FETCH.
- AUIPC: a=1, b=1, imm_src=U, ADD, then ALUWB.
- HALT: halted=1, all enables 0, remains until reset.

Boundary conditions:
- Reset asserted mid-instruction aborts immediately; no partial write is issued after the reset edge.
- MEM_WAIT=0 gives a 1-cycle FETCH.
- Counter clears on every state entry.
- Latencies with MEM_WAIT=1: R/I-type 5, load 7, store 5, branch 4, jal 5, jalr 6, lui 4 cycles.

Test Plan:
- Reset low for 3 cycles, then release → next cycle is FETCH with adr_src=0 and IR_write=0; IR_write=PC_write=1 on the second FETCH cycle (MEM_WAIT=1).
- add x3,x1,x2 (0x002081B3) in IR → DECODE, EXEC_R(alu_control=0), ALUWB with reg_write=1 and result_src=0; 5 cycles total. Repeat with sub (0x402081B3) → alu_control=1.
- lw (0x0000A183) → MEMADR(imm_src=0), MEMREAD with adr_src=1 for 2 cycles, MEMWB with result_src=1 and reg_write=1. sw (0x0030A023) → exactly one mem_write pulse, imm_src=1.
- beq (0x00208463) with Zero=1 → PC_write=1 in BRANCH. With Zero=0 → PC_write=0. bge (funct3=101) with Zero=0 → PC_write=0, alu_control=5.
- jal (0x008000EF) → DECODE imm_src=3, JAL PC_write=1, then ALUWB reg_write=1. jalr (0x000080E7) → JALR_ADR then JALR_JMP, PC_write=1.
- op_code 0x7F → HALT with halted=1, illegal_instr=1, all enables 0 for 20 cycles. Reset low mid-MEMREAD → state FETCH, no mem_write or reg_write afterwards.
